// File: rtl/sweep_ctrl.sv
// ---------------------------------------------------------------------------
// sweep_ctrl
//
// Frequency-sweep sequencer for the sine generator. It drives the
// generator's en / incr / phase_offset inputs. The output frequency steps
// linearly from a start increment to a stop increment, and each step is held
// for a programmed number of dwell cycles. A sweep either runs once or
// repeats until it is stopped.
//
// Parameters
//   D_WIDTH   width of the increment and phase-offset values
//   DW_WIDTH  width of the dwell counter
//
// Ports
//   clk, rst         clock; asynchronous active-high reset
//   cfg_valid        configuration word valid
//   cfg_ready        configuration accepted this cycle if cfg_valid (IDLE only)
//   cfg_start_incr   first increment of the sweep
//   cfg_stop_incr    last increment of the sweep
//   cfg_step         increment delta per step (0 behaves as 1)
//   cfg_dwell        cycles each increment is held (0 behaves as 1)
//   cfg_phase        phase offset driven for the whole sweep
//   cfg_repeat       1: wrap to start after the last step, 0: single pass
//   start            begin a sweep (sampled in IDLE)
//   stop             abort the sweep (sampled in RUN)
//   en               generator enable
//   incr             generator address increment
//   phase_offset     generator phase offset
//   busy             high while sweeping
//   done             one-cycle pulse when a single-pass sweep completes
//   state_dbg        current FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Handshake: a configuration transfer happens on a rising clk edge where
// cfg_valid and cfg_ready are both high. cfg_ready is decoded from the state
// and does not depend on cfg_valid. All cfg_* fields are captured together
// on that edge. cfg_valid has no effect while cfg_ready is low.
// ---------------------------------------------------------------------------
module sweep_ctrl #(
    parameter int D_WIDTH  = 8,
    parameter int DW_WIDTH = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [D_WIDTH-1:0]  cfg_start_incr,
    input  logic [D_WIDTH-1:0]  cfg_stop_incr,
    input  logic [D_WIDTH-1:0]  cfg_step,
    input  logic [DW_WIDTH-1:0] cfg_dwell,
    input  logic [D_WIDTH-1:0]  cfg_phase,
    input  logic                cfg_repeat,
    input  logic                start,
    input  logic                stop,
    output logic                en,
    output logic [D_WIDTH-1:0]  incr,
    output logic [D_WIDTH-1:0]  phase_offset,
    output logic                busy,
    output logic                done,
    output logic [1:0]          state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [D_WIDTH-1:0]  D_ONE  = D_WIDTH'(1);
    localparam logic [D_WIDTH-1:0]  D_ZERO = '0;
    localparam logic [DW_WIDTH-1:0] DW_ONE = DW_WIDTH'(1);

    state_t state;

    // Latched configuration. Step and dwell are stored already normalised,
    // so a programmed 0 is kept as 1. This keeps the run-time compare and
    // step logic free of zero special cases.
    logic [D_WIDTH-1:0]  start_r;
    logic [D_WIDTH-1:0]  stop_r;
    logic [D_WIDTH-1:0]  step_r;
    logic [DW_WIDTH-1:0] dwell_r;
    logic [D_WIDTH-1:0]  phase_r;
    logic                repeat_r;

    logic [DW_WIDTH-1:0] dwell_cnt;

    // Handshake and normalised incoming fields
    logic                cfg_xfer;
    logic [D_WIDTH-1:0]  step_in;
    logic [DW_WIDTH-1:0] dwell_in;

    // A start on the same edge as a transfer must use the new values, so
    // the sweep seed is taken from the inputs in that case.
    logic [D_WIDTH-1:0]  eff_start;
    logic [D_WIDTH-1:0]  eff_phase;

    // Step computation
    logic                sweep_up;
    logic                at_stop;
    logic                step_edge;
    logic [D_WIDTH:0]    sum_ext;
    logic [D_WIDTH-1:0]  diff;
    logic [D_WIDTH-1:0]  next_incr;

    assign cfg_ready = (state == S_IDLE);
    assign state_dbg = state;

    assign cfg_xfer  = cfg_valid && cfg_ready;
    assign step_in   = (cfg_step  == D_ZERO)   ? D_ONE  : cfg_step;
    assign dwell_in  = (cfg_dwell == '0)       ? DW_ONE : cfg_dwell;

    assign eff_start = cfg_xfer ? cfg_start_incr : start_r;
    assign eff_phase = cfg_xfer ? cfg_phase      : phase_r;

    assign sweep_up  = (start_r <= stop_r);
    assign at_stop   = (incr == stop_r);
    assign step_edge = (dwell_cnt == (dwell_r - DW_ONE));

    // The sum is one bit wider so that an up step cannot wrap past the top
    // of the range. Anything at or above stop saturates to stop.
    assign sum_ext   = {1'b0, incr} + {1'b0, step_r};
    // In a down sweep incr never falls below stop, so this cannot underflow.
    assign diff      = incr - stop_r;

    always_comb begin
        next_incr = incr;
        if (sweep_up) begin
            if (sum_ext >= {1'b0, stop_r}) begin
                next_incr = stop_r;
            end else begin
                next_incr = sum_ext[D_WIDTH-1:0];
            end
        end else begin
            if (diff <= step_r) begin
                next_incr = stop_r;
            end else begin
                next_incr = incr - step_r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            en           <= 1'b0;
            incr         <= '0;
            phase_offset <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            dwell_cnt    <= '0;
            start_r      <= D_ONE;
            stop_r       <= D_ONE;
            step_r       <= D_ONE;
            dwell_r      <= DW_ONE;
            phase_r      <= '0;
            repeat_r     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (cfg_xfer) begin
                        start_r  <= cfg_start_incr;
                        stop_r   <= cfg_stop_incr;
                        step_r   <= step_in;
                        dwell_r  <= dwell_in;
                        phase_r  <= cfg_phase;
                        repeat_r <= cfg_repeat;
                    end
                    if (start) begin
                        state        <= S_RUN;
                        incr         <= eff_start;
                        phase_offset <= eff_phase;
                        en           <= 1'b1;
                        busy         <= 1'b1;
                        dwell_cnt    <= '0;
                    end
                end

                S_RUN: begin
                    if (stop) begin
                        // An abort wins over a step edge on the same cycle.
                        // incr and phase_offset hold their last values.
                        state     <= S_IDLE;
                        en        <= 1'b0;
                        busy      <= 1'b0;
                        dwell_cnt <= '0;
                    end else if (step_edge) begin
                        dwell_cnt <= '0;
                        if (!at_stop) begin
                            incr <= next_incr;
                        end else if (repeat_r) begin
                            // Wrapping costs no extra cycle. When start equals
                            // stop, this holds the same value until stopped.
                            incr <= start_r;
                        end else begin
                            state <= S_DONE;
                            en    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DW_ONE;
                    end
                end

                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                    en    <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sweep_ctrl.sv
module tb_sweep_ctrl;

    localparam int W = 17;  // {done, phase_offset[7:0], incr[7:0]}

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [7:0]  cfg_start_incr = '0;
    logic [7:0]  cfg_stop_incr = '0;
    logic [7:0]  cfg_step = '0;
    logic [15:0] cfg_dwell = '0;
    logic [7:0]  cfg_phase = '0;
    logic        cfg_repeat = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        en;
    logic [7:0]  incr;
    logic [7:0]  phase_offset;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    int total = 0;
    int bad = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] mon_act;
    logic [W-1:0] mon_exp;

    sweep_ctrl #(.D_WIDTH(8), .DW_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_valid      (cfg_valid),
        .cfg_ready      (cfg_ready),
        .cfg_start_incr (cfg_start_incr),
        .cfg_stop_incr  (cfg_stop_incr),
        .cfg_step       (cfg_step),
        .cfg_dwell      (cfg_dwell),
        .cfg_phase      (cfg_phase),
        .cfg_repeat     (cfg_repeat),
        .start          (start),
        .stop           (stop),
        .en             (en),
        .incr           (incr),
        .phase_offset   (phase_offset),
        .busy           (busy),
        .done           (done),
        .state_dbg      (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard monitor ----------------
    // Every cycle with en or done high is one output event.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b0 && (en === 1'b1 || done === 1'b1)) begin
                mon_act = {done, phase_offset, incr};
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got done=%0b phase=%0d incr=%0d, required no output", done, phase_offset, incr);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        bad++;
                        $display("FAIL sb_event: got done=%0b phase=%0d incr=%0d, required done=%0b phase=%0d incr=%0d",
                                 mon_act[16], mon_act[15:8], mon_act[7:0], mon_exp[16], mon_exp[15:8], mon_exp[7:0]);
                    end
                end
            end
        end
    end

    // ---------------- driver / check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic push_ev(input logic d, input logic [7:0] ph, input logic [7:0] inc);
        exp_q.push_back({d, ph, inc});
    endtask

    task automatic load_cfg(input logic [7:0] s, input logic [7:0] p, input logic [7:0] st,
                            input logic [15:0] dw, input logic [7:0] ph, input logic rep,
                            input logic with_start);
        cfg_start_incr = s;
        cfg_stop_incr  = p;
        cfg_step       = st;
        cfg_dwell      = dw;
        cfg_phase      = ph;
        cfg_repeat     = rep;
        cfg_valid      = 1'b1;
        start          = with_start;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int bound);
        int n;
        n = 0;
        while (cfg_ready !== 1'b1 && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        total++;
        if (cfg_ready !== 1'b1) begin
            bad++;
            $display("FAIL %s: cfg_ready still %0b after %0d cycles, required 1", name, cfg_ready, bound);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // reset from power-up
        #1 rst = 1'b1;
        #2;
        check("rst_en", en, 0);
        check("rst_incr", incr, 0);
        check("rst_phase", phase_offset, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", cfg_ready, 1);
        check("rst_state", state_dbg, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // up sweep, single pass
        load_cfg(8'd4, 8'd16, 8'd5, 16'd3, 8'd64, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) push_ev(1'b0, 8'd64, 8'd4);
        for (int i = 0; i < 3; i++) push_ev(1'b0, 8'd64, 8'd9);
        for (int i = 0; i < 3; i++) push_ev(1'b0, 8'd64, 8'd14);
        for (int i = 0; i < 3; i++) push_ev(1'b0, 8'd64, 8'd16);
        push_ev(1'b1, 8'd64, 8'd16);
        do_start();
        check("up_first_en", en, 1);
        check("up_first_incr", incr, 4);
        check("up_busy", busy, 1);
        check("up_ready_low", cfg_ready, 0);
        wait_idle("up_idle", 50);
        check("up_sb_empty", exp_q.size(), 0);
        check("idle_hold_incr", incr, 16);
        check("idle_hold_phase", phase_offset, 64);
        check("idle_en", en, 0);

        // down sweep, step larger than remaining distance
        load_cfg(8'd250, 8'd2, 8'd100, 16'd1, 8'd3, 1'b0, 1'b0);
        push_ev(1'b0, 8'd3, 8'd250);
        push_ev(1'b0, 8'd3, 8'd150);
        push_ev(1'b0, 8'd3, 8'd50);
        push_ev(1'b0, 8'd3, 8'd2);
        push_ev(1'b1, 8'd3, 8'd2);
        do_start();
        wait_idle("down_idle", 50);
        check("down_sb_empty", exp_q.size(), 0);

        // up sweep whose sum exceeds the value range saturates at stop
        load_cfg(8'd200, 8'd255, 8'd100, 16'd1, 8'd9, 1'b0, 1'b0);
        push_ev(1'b0, 8'd9, 8'd200);
        push_ev(1'b0, 8'd9, 8'd255);
        push_ev(1'b1, 8'd9, 8'd255);
        do_start();
        wait_idle("sat_idle", 50);
        check("sat_sb_empty", exp_q.size(), 0);

        // repeat sweep with cfg_valid held during RUN, then abort
        load_cfg(8'd1, 8'd3, 8'd1, 16'd2, 8'd7, 1'b1, 1'b0);
        push_ev(1'b0, 8'd7, 8'd1); push_ev(1'b0, 8'd7, 8'd1);
        push_ev(1'b0, 8'd7, 8'd2); push_ev(1'b0, 8'd7, 8'd2);
        push_ev(1'b0, 8'd7, 8'd3); push_ev(1'b0, 8'd7, 8'd3);
        push_ev(1'b0, 8'd7, 8'd1); push_ev(1'b0, 8'd7, 8'd1);
        push_ev(1'b0, 8'd7, 8'd2);
        do_start();
        cfg_start_incr = 8'd99;
        cfg_stop_incr  = 8'd99;
        cfg_step       = 8'd9;
        cfg_dwell      = 16'd9;
        cfg_phase      = 8'd99;
        cfg_repeat     = 1'b0;
        cfg_valid      = 1'b1;
        check("run_ready_low", cfg_ready, 0);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
        end
        check("run_ready_low_late", cfg_ready, 0);
        cfg_valid = 1'b0;
        stop      = 1'b1;
        @(posedge clk);
        #1;
        stop = 1'b0;
        check("abort_en", en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_incr", incr, 2);
        check("abort_ready", cfg_ready, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
        end
        check("abort_no_done", done, 0);
        check("rep_sb_empty", exp_q.size(), 0);

        // config transfer and start on the same edge
        push_ev(1'b0, 8'd5, 8'd7);
        push_ev(1'b0, 8'd5, 8'd9);
        push_ev(1'b1, 8'd5, 8'd9);
        load_cfg(8'd7, 8'd9, 8'd2, 16'd1, 8'd5, 1'b0, 1'b1);
        check("same_edge_incr", incr, 7);
        check("same_edge_en", en, 1);
        wait_idle("same_edge_idle", 50);
        check("same_edge_sb_empty", exp_q.size(), 0);

        // zero step and dwell behave as 1
        load_cfg(8'd0, 8'd2, 8'd0, 16'd0, 8'd0, 1'b0, 1'b0);
        push_ev(1'b0, 8'd0, 8'd0);
        push_ev(1'b0, 8'd0, 8'd1);
        push_ev(1'b0, 8'd0, 8'd2);
        push_ev(1'b1, 8'd0, 8'd2);
        do_start();
        wait_idle("zero_idle", 50);
        check("zero_sb_empty", exp_q.size(), 0);

        // asynchronous reset in the middle of a long sweep
        load_cfg(8'd10, 8'd20, 8'd1, 16'd100, 8'd33, 1'b0, 1'b0);
        push_ev(1'b0, 8'd33, 8'd10);
        do_start();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_en", en, 0);
        check("arst_incr", incr, 0);
        check("arst_phase", phase_offset, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_ready", cfg_ready, 1);
        check("arst_sb_empty", exp_q.size(), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // sweep with the reset configuration: start 1 stop 1 dwell 1 phase 0
        push_ev(1'b0, 8'd0, 8'd1);
        push_ev(1'b1, 8'd0, 8'd1);
        do_start();
        wait_idle("defcfg_idle", 50);
        check("defcfg_sb_empty", exp_q.size(), 0);

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
